pwm_multi: RTL
==============

Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; next generation of the single-channel LED PWM in the leds subsystem.
- All channels share one period counter with a programmable period.
- Each channel has a shadowed duty and polarity setting, so updates take effect only at the period boundary and never glitch.
- Drives board LEDs and any other PWM-dimmed outputs from the fabric.

Parameters:
- WIDTH, 11, bit width of counter, period and duty values.
- NUM_CH, 4, number of PWM channels (1..32).
- FADE_STEP, 1, duty increment per period in fade mode; used only when PWM_FADE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  run enable for the shared counter.
- period  in  WIDTH  terminal count; one period is period+1 cycles.
- cfg_we  in  1  write strobe for one channel's shadow registers.
- cfg_ch  in  max(1,$clog2(NUM_CH))  channel index for the write.
- cfg_duty  in  WIDTH  duty value; high cycles per period when not inverted.
- cfg_inv  in  1  polarity for the written channel (1 = inverted output).
- out  out  NUM_CH  registered PWM outputs.
- cycle_start  out  1  one-cycle pulse marking the first cycle of each period.

Behaviour:
- Reset (rst_n=0, async): counter=0; shadow duty/inv=0; active duty/inv=0; out=0; cycle_start=0.
- Counter when en=1: if counter >= period then next counter=0, else counter+1. The >= covers period being lowered below the current count, which forces an immediate wrap. period=0 gives counter stuck at 0.
- Counter when en=0: counter held at 0. Active registers continuously load the shadows. Outputs go to the inactive level: out[i]=inv_act[i].
- Wrap event: en=1 and counter >= period. On a wrap, every channel copies shadow duty/inv into its active registers.
- Write: cfg_we=1 with cfg_ch<NUM_CH writes that channel's shadow duty/inv. cfg_ch>=NUM_CH is ignored.
- Write coinciding with a wrap: the active registers load the pre-write shadow. The new value takes effect at the following wrap.
- Compare: raw[i] = (counter < duty_act[i]). out[i] is registered as raw[i] ^ inv_act[i], so out lags counter by exactly 1 cycle.
- Duty boundaries: duty=0 gives raw always 0. duty > period gives raw always 1. duty=period gives period high cycles out of period+1.
- cycle_start: registered, high for the cycle in which out reflects counter=0 (en=1 only). Never asserted while en=0.
- Restart: en 0→1 starts counting from 0. The first cycle_start appears 1 cycle after en rises.
- Width rules: all comparisons unsigned WIDTH-bit. No arithmetic overflow beyond the counter, which never exceeds period.

Optional Feature:
- Macro PWM_FADE_EN.
- Defined: at each wrap, duty_act moves toward the shadow duty by FADE_STEP, saturating exactly at the target without overshoot. inv_act still loads immediately. With en=0 the active registers still jump directly to the shadow values.
- Undefined: duty_act loads the shadow directly at each wrap. FADE_STEP is unused.
- Ports are identical in both builds.

Decomposition:
- Package pwm_pkg: default WIDTH/NUM_CH constants and a channel-index-width function.
- Sub-module pwm_channel: one channel's shadow/active registers, fade logic, compare and output flop. Instantiated NUM_CH times by pwm_multi, which owns the counter, wrap detection, write decode and cycle_start.

Test Plan:
- Reset mid-run: assert rst_n=0 while en=1, counter=5 → out=0 and cycle_start=0 immediately, without waiting for a clock edge. Counter restarts from 0 after release with en=1.
- Basic duty: period=9, ch0 duty=3, inv=0, en=1 → out[0] high 3 of every 10 cycles. cycle_start pulses every 10 cycles, aligned with the first high cycle of out[0].
- Shadow timing: mid-period write ch1 duty 2→7 → current period stays at 2 high cycles, the next period has 7. A write in the same cycle as the wrap takes effect one period later.
- Boundaries: duty=0 → out constant 0. duty=12 with period=9 → constant 1. inv=1 with duty=0 → constant 1. en=0 with inv=1 → out=1. cfg_ch=NUM_CH write → no channel changes.
- Period shrink: counter=8, period changed 9→4 → wrap on the next edge. Subsequent periods are 5 cycles long.
- Fade (PWM_FADE_EN, FADE_STEP=2): duty 0→5 → active duty per period is 2, 4, 5, then stays at 5. A downward change 5→0 gives 3, 1, 0.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared defaults and the channel-index width helper for pwm_multi.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   localparam int DEF_WIDTH  = 11;
   localparam int DEF_NUM_CH = 4;

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM channel: shadow/active duty and polarity, compare, output
//            flop. Optional duty fading under PWM_FADE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
#(
   parameter int WIDTH     = 11,
   parameter int FADE_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_i,
   input  logic             wrap_i,
   input  logic             we_i,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic [WIDTH-1:0] duty_i,
   input  logic             inv_i,
   output logic             out_o
);

`ifdef PWM_FADE_EN
   localparam logic [WIDTH:0] c_step = (WIDTH+1)'(FADE_STEP);
`else
   // A step of 2**WIDTH always saturates, so the active duty takes the shadow directly.
   localparam logic [WIDTH:0] c_step = (WIDTH+1)'(FADE_STEP * 0 + (1 << WIDTH));
`endif

   logic [WIDTH-1:0] duty_sh_q;
   logic [WIDTH-1:0] duty_act_q;
   logic [WIDTH-1:0] duty_act_d;
   logic             inv_sh_q;
   logic             inv_act_q;
   logic             out_q;
   logic             out_d;
   logic [WIDTH:0]   w_act;
   logic [WIDTH:0]   w_sh;

   assign w_act = {1'b0, duty_act_q};
   assign w_sh  = {1'b0, duty_sh_q};

   always_comb begin
      duty_act_d = duty_act_q;
      if (!run_i) begin
         duty_act_d = duty_sh_q;
      end else if (wrap_i) begin
         if (w_sh > w_act) begin
            duty_act_d = ((w_sh - w_act) > c_step) ? duty_act_q + c_step[WIDTH-1:0] : duty_sh_q;
         end else begin
            duty_act_d = ((w_act - w_sh) > c_step) ? duty_act_q - c_step[WIDTH-1:0] : duty_sh_q;
         end
      end
   end

   always_comb begin
      out_d = inv_act_q;
      if (run_i) begin
         out_d = (cnt_i < duty_act_q) ^ inv_act_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_sh_q  <= '0;
         inv_sh_q   <= 1'b0;
         duty_act_q <= '0;
         inv_act_q  <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         // Active registers sample the pre-write shadow when a write lands on a wrap.
         if (we_i) begin
            duty_sh_q <= duty_i;
            inv_sh_q  <= inv_i;
         end
         duty_act_q <= duty_act_d;
         if (!run_i || wrap_i) begin
            inv_act_q <= inv_sh_q;
         end
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM with a shared period counter and shadowed
//            per-channel duty/polarity. Duty fading selected by PWM_FADE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int FADE_STEP = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [WIDTH-1:0]             period,
   input  logic                         cfg_we,
   input  logic [ch_idx_w(NUM_CH)-1:0]  cfg_ch,
   input  logic [WIDTH-1:0]             cfg_duty,
   input  logic                         cfg_inv,
   output logic [NUM_CH-1:0]            out,
   output logic                         cycle_start
);

   localparam int c_ch_w = ch_idx_w(NUM_CH);

   logic [WIDTH-1:0]  counter_q;
   logic [WIDTH-1:0]  counter_d;
   logic              cycle_start_q;
   logic              w_wrap;
   logic [NUM_CH-1:0] w_we;

   // >= rather than == so a period lowered below the count wraps at once.
   assign w_wrap = en && (counter_q >= period);

   always_comb begin
      counter_d = counter_q + WIDTH'(1);
      if (!en || w_wrap) begin
         counter_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q     <= '0;
         cycle_start_q <= 1'b0;
      end else begin
         counter_q     <= counter_d;
         cycle_start_q <= en && (counter_q == '0);
      end
   end

   assign cycle_start = cycle_start_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign w_we[gi] = cfg_we && (cfg_ch == c_ch_w'(gi));

         pwm_channel #(
            .WIDTH     (WIDTH),
            .FADE_STEP (FADE_STEP)
         ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .run_i  (en),
            .wrap_i (w_wrap),
            .we_i   (w_we[gi]),
            .cnt_i  (counter_q),
            .duty_i (cfg_duty),
            .inv_i  (cfg_inv),
            .out_o  (out[gi])
         );
      end
   endgenerate

endmodule
`default_nettype wire
